// File: rtl/nes_pkg.sv
// Shared types and constants for the NES controller receiver.
// FSM encodings, button bit positions and the released-button word.
package nes_pkg;

  typedef logic [2:0] state_t;

  localparam state_t ST_IDLE  = 3'd0;
  localparam state_t ST_LATCH = 3'd1;
  localparam state_t ST_LOW   = 3'd2;
  localparam state_t ST_HIGH  = 3'd3;
  localparam state_t ST_DONE  = 3'd4;

  localparam int BTN_A      = 0;
  localparam int BTN_B      = 1;
  localparam int BTN_SELECT = 2;
  localparam int BTN_START  = 3;
  localparam int BTN_UP     = 4;
  localparam int BTN_DOWN   = 5;
  localparam int BTN_LEFT   = 6;
  localparam int BTN_RIGHT  = 7;

  localparam logic [7:0] BTN_RELEASED = 8'hFF;

endpackage

// File: rtl/nes_sync.sv
// Two-flop synchronizer for the asynchronous controller data line.
// Resets to 1 so an unread line looks like a released button.
module nes_sync (
  input  logic clk,
  input  logic reset_n,
  input  logic d,
  output logic q
);

  logic meta_q;
  logic sync_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      meta_q <= 1'b1;
      sync_q <= 1'b1;
    end else begin
      meta_q <= d;
      sync_q <= meta_q;
    end
  end

  assign q = sync_q;

endmodule

// File: rtl/nes_receiver.sv
// NES controller poller: latches, clocks out and registers the 8 active-low buttons.
// Build option NES_DEBOUNCE_EN: only accept a frame that matches the previous raw frame.
module nes_receiver
  import nes_pkg::*;
#(
  parameter int HALF_PERIOD = 12,
  parameter int POLL_PERIOD = 34667
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       nes_data,
  output logic       nes_latch,
  output logic       nes_pulse,
  output logic [7:0] buttons,
  output logic       up,
  output logic       down,
  output logic       left,
  output logic       right,
  output logic       btn_valid
);

  localparam int POLL_W  = (POLL_PERIOD > 1) ? $clog2(POLL_PERIOD) : 1;
  localparam int PHASE_W = $clog2(2 * HALF_PERIOD);

  localparam logic [POLL_W-1:0]  POLL_LAST  = POLL_W'(POLL_PERIOD - 1);
  localparam logic [PHASE_W-1:0] LATCH_LAST = PHASE_W'(2 * HALF_PERIOD - 1);
  localparam logic [PHASE_W-1:0] HALF_LAST  = PHASE_W'(HALF_PERIOD - 1);

  logic data_sync;

  state_t              state_q,   state_d;
  logic [POLL_W-1:0]   poll_q,    poll_d;
  logic [PHASE_W-1:0]  phase_q,   phase_d;
  logic [2:0]          idx_q,     idx_d;
  logic [7:0]          shift_q,   shift_d;
  logic [7:0]          buttons_q, buttons_d;
  logic                latch_q,   latch_d;
  logic                pulse_q,   pulse_d;
  logic                valid_q,   valid_d;
`ifdef NES_DEBOUNCE_EN
  logic [7:0]          raw_q,     raw_d;
`endif

  nes_sync u_sync (
    .clk     (clk),
    .reset_n (reset_n),
    .d       (nes_data),
    .q       (data_sync)
  );

  always_comb begin
    poll_d    = (poll_q == POLL_LAST) ? '0 : poll_q + 1'b1;
    state_d   = state_q;
    phase_d   = phase_q;
    idx_d     = idx_q;
    shift_d   = shift_q;
    buttons_d = buttons_q;
    latch_d   = latch_q;
    pulse_d   = pulse_q;
    valid_d   = 1'b0;
`ifdef NES_DEBOUNCE_EN
    raw_d     = raw_q;
`endif

    case (state_q)
      // Frames only start from IDLE; a wrap seen mid-frame is simply dropped.
      ST_IDLE: begin
        if (poll_q == POLL_LAST) begin
          state_d = ST_LATCH;
          latch_d = 1'b1;
          phase_d = '0;
        end
      end

      ST_LATCH: begin
        if (phase_q == LATCH_LAST) begin
          state_d = ST_LOW;
          latch_d = 1'b0;
          phase_d = '0;
          idx_d   = 3'd0;
        end else begin
          phase_d = phase_q + 1'b1;
        end
      end

      // Sample at the end of the low half, long after the previous rising edge shifted the controller.
      ST_LOW: begin
        if (phase_q == HALF_LAST) begin
          shift_d[idx_q] = data_sync;
          state_d        = ST_HIGH;
          pulse_d        = 1'b1;
          phase_d        = '0;
        end else begin
          phase_d = phase_q + 1'b1;
        end
      end

      ST_HIGH: begin
        if (phase_q == HALF_LAST) begin
          pulse_d = 1'b0;
          phase_d = '0;
          if (idx_q == 3'd7) begin
            state_d = ST_DONE;
          end else begin
            idx_d   = idx_q + 3'd1;
            state_d = ST_LOW;
          end
        end else begin
          phase_d = phase_q + 1'b1;
        end
      end

      ST_DONE: begin
        state_d = ST_IDLE;
`ifdef NES_DEBOUNCE_EN
        raw_d = shift_q;
        if ((shift_q == raw_q) && (shift_q != buttons_q)) begin
          buttons_d = shift_q;
          valid_d   = 1'b1;
        end
`else
        buttons_d = shift_q;
        valid_d   = 1'b1;
`endif
      end

      default: begin
        state_d = ST_IDLE;
        latch_d = 1'b0;
        pulse_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= ST_IDLE;
      poll_q    <= '0;
      phase_q   <= '0;
      idx_q     <= 3'd0;
      shift_q   <= BTN_RELEASED;
      buttons_q <= BTN_RELEASED;
      latch_q   <= 1'b0;
      pulse_q   <= 1'b0;
      valid_q   <= 1'b0;
`ifdef NES_DEBOUNCE_EN
      raw_q     <= BTN_RELEASED;
`endif
    end else begin
      state_q   <= state_d;
      poll_q    <= poll_d;
      phase_q   <= phase_d;
      idx_q     <= idx_d;
      shift_q   <= shift_d;
      buttons_q <= buttons_d;
      latch_q   <= latch_d;
      pulse_q   <= pulse_d;
      valid_q   <= valid_d;
`ifdef NES_DEBOUNCE_EN
      raw_q     <= raw_d;
`endif
    end
  end

  assign nes_latch = latch_q;
  assign nes_pulse = pulse_q;
  assign buttons   = buttons_q;
  assign btn_valid = valid_q;
  assign up        = buttons_q[BTN_UP];
  assign down      = buttons_q[BTN_DOWN];
  assign left      = buttons_q[BTN_LEFT];
  assign right     = buttons_q[BTN_RIGHT];

endmodule

// File: tb/tb_nes_receiver.sv
// Scoreboard bench for nes_receiver with a behavioural NES controller model.
// Build with NES_DEBOUNCE_EN defined to run the debounce sequence instead.
module tb_nes_receiver;
  import nes_pkg::*;

  localparam int HALF = 2;
  localparam int POLL = 64;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       nes_data = 1'b1;
  logic       nes_latch;
  logic       nes_pulse;
  logic [7:0] buttons;
  logic       up, down, left, right;
  logic       btn_valid;

  logic [7:0] ctrl_frame = 8'hFF;
  logic [7:0] exp_btn = 8'hFF;
  logic [7:0] exp_q[$];

  int pass_cnt = 0;
  int total_cnt = 0;
  int cyc = 0;
  int rise_cnt = 0;
  int last_rise = 0;
  int prev_rise = 0;
  logic latch_prev = 1'b0;
  logic valid_prev = 1'b0;
  logic pulse_prev = 1'b0;
  int ctl_idx = 8;

  nes_receiver #(.HALF_PERIOD(HALF), .POLL_PERIOD(POLL)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .nes_data  (nes_data),
    .nes_latch (nes_latch),
    .nes_pulse (nes_pulse),
    .buttons   (buttons),
    .up        (up),
    .down      (down),
    .left      (left),
    .right     (right),
    .btn_valid (btn_valid)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc++;

  task automatic checkOutput(input string name, input int actual, input int expected);
    total_cnt++;
    if (actual == expected) pass_cnt++;
    else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, actual, expected, cyc);
  endtask

  // Controller model: latch reloads bit 0, each rising pulse edge shifts to the next bit.
  always @(negedge clk) begin
    if (!reset_n) begin
      ctl_idx = 8;
    end else if (nes_latch) begin
      ctl_idx = 0;
    end else if (nes_pulse && !pulse_prev) begin
      ctl_idx++;
    end
    pulse_prev = nes_pulse;
    nes_data   = (ctl_idx < 8) ? ctrl_frame[ctl_idx[2:0]] : 1'b1;
  end

  always @(negedge clk) begin
    if (nes_latch && !latch_prev) begin
      prev_rise = last_rise;
      last_rise = cyc;
      rise_cnt++;
    end
    latch_prev = nes_latch;
  end

  // Monitor: every btn_valid strobe consumes one expected frame.
  always @(negedge clk) begin
    if (reset_n && btn_valid) begin
      checkOutput("valid_width", int'(valid_prev), 0);
      if (exp_q.size() == 0) begin
        checkOutput("unexpected_valid", 1, 0);
      end else begin
        automatic logic [7:0] e = exp_q.pop_front();
        checkOutput("buttons", buttons, e);
        checkOutput("up", up, e[BTN_UP]);
        checkOutput("down", down, e[BTN_DOWN]);
        checkOutput("left", left, e[BTN_LEFT]);
        checkOutput("right", right, e[BTN_RIGHT]);
      end
    end
    valid_prev = reset_n && btn_valid;
  end

  task automatic applyStimulus(input logic [7:0] frame, input bit expect_update);
    int start = rise_cnt;
    int n = 0;
    ctrl_frame = frame;
    if (expect_update) begin
      exp_q.push_back(frame);
      exp_btn = frame;
    end
    while (rise_cnt == start && n < 200) begin
      @(negedge clk);
      n++;
    end
    checkOutput("frame_started", int'(rise_cnt != start), 1);
    repeat (40) @(negedge clk);
    checkOutput("scoreboard_drained", exp_q.size(), 0);
    checkOutput("buttons_hold", buttons, exp_btn);
  endtask

  task automatic measureFrame(input int rel_cyc);
    int n = 0;
    int lat_bad = 0;
    int pul_bad = 0;
    while (!nes_latch && n < 300) begin
      @(negedge clk);
      n++;
    end
    checkOutput("first_latch_cycle", cyc - rel_cyc, POLL);
    for (int k = 0; k < 60; k++) begin
      automatic int j = k - 4;
      automatic logic exp_l = (k < 4);
      automatic logic exp_p = (k >= 4) && (j < 32) && ((j % 4) >= 2);
      if (nes_latch !== exp_l) lat_bad++;
      if (nes_pulse !== exp_p) pul_bad++;
      @(negedge clk);
    end
    checkOutput("latch_waveform_errs", lat_bad, 0);
    checkOutput("pulse_waveform_errs", pul_bad, 0);
  endtask

  task automatic checkReset(input string tag);
    checkOutput({tag, "_buttons"}, buttons, 8'hFF);
    checkOutput({tag, "_latch"}, nes_latch, 0);
    checkOutput({tag, "_pulse"}, nes_pulse, 0);
    checkOutput({tag, "_valid"}, btn_valid, 0);
  endtask

  initial begin
    int rel;
    int n;
    reset_n = 1'b0;
    repeat (5) @(posedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    rel = cyc;
    checkReset("reset");

`ifdef NES_DEBOUNCE_EN
    fork
      applyStimulus(8'hDF, 1'b0);
      measureFrame(rel);
    join
    applyStimulus(8'hEF, 1'b0);
    checkOutput("latch_period", last_rise - prev_rise, POLL);
    applyStimulus(8'hEF, 1'b1);
    applyStimulus(8'hEF, 1'b0);
`else
    // Down only pressed: serial 1,1,1,1,1,0,1,1
    fork
      applyStimulus(8'hDF, 1'b1);
      measureFrame(rel);
    join
    applyStimulus(8'hDF, 1'b1);
    checkOutput("latch_period", last_rise - prev_rise, POLL);

    // Abort a frame presenting all-pressed while bit 3 is being clocked.
    ctrl_frame = 8'h00;
    n = 0;
    while (!nes_latch && n < 100) begin
      @(negedge clk);
      n++;
    end
    repeat (18) @(negedge clk);
    #1 reset_n = 1'b0;
    exp_btn = 8'hFF;
    #1 checkReset("async_reset");
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    rel = cyc;
    fork
      applyStimulus(8'h00, 1'b1);
      begin
        int m = 0;
        while (!nes_latch && m < 300) begin
          @(negedge clk);
          m++;
        end
        checkOutput("restart_latch_cycle", cyc - rel, POLL);
        checkOutput("buttons_after_abort", buttons, 8'hFF);
      end
    join

    applyStimulus(8'hFF, 1'b1);
    applyStimulus(8'h00, 1'b1);
`endif

    repeat (5) @(negedge clk);
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish, %0d/%0d passed", pass_cnt, total_cnt);
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
